// File: rtl/handshake_pkg.sv
// Shared types and constants for the four-phase req/ack receiver.
// Provides FSM state encodings and the default data width.
package handshake_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_ACK     = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser with async active-low reset.
// Ports: clk, rst_n, d (async level in), q (synchronised level out).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/handshake_receiver.sv
// Receive side of a four-phase req/ack CDC handshake with an output buffer.
// Ports: bclk, brst, breq, bdin in; back, bdata, bvalid, bload, bstate out; bready in.
module handshake_receiver
  import handshake_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic              bclk,
  input  logic              brst,
  input  logic              breq,
  input  logic [DATA_W-1:0] bdin,
  output logic              back,
  output logic [DATA_W-1:0] bdata,
  output logic              bvalid,
  input  logic              bready,
  output logic              bload,
  output logic [1:0]        bstate
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic              req_s;
  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW-1:0]     wptr_n, rptr_n;
  logic [CW-1:0]     count, count_n;
  logic [DATA_W-1:0] head_n;
  logic              push, pop;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (bclk),
    .rst_n(brst),
    .d    (breq),
    .q    (req_s)
  );

  assign push   = (state == ST_CAPTURE);
  assign pop    = bvalid && bready;
  assign bstate = state;

  always_comb begin
    wptr_n  = push ? wptr + AW'(1) : wptr;
    rptr_n  = pop  ? rptr + AW'(1) : rptr;
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    // the word being written this edge may become the new head
    if (push && (wptr == rptr_n)) head_n = bdin;
    else                          head_n = mem[rptr_n];
  end

  always_ff @(posedge bclk) begin
    if (push) mem[wptr] <= bdin;
  end

  always_ff @(posedge bclk or negedge brst) begin
    if (!brst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      bvalid <= 1'b0;
      bdata  <= '0;
    end else begin
      wptr   <= wptr_n;
      rptr   <= rptr_n;
      count  <= count_n;
      bvalid <= (count_n != '0);
      bdata  <= head_n;
    end
  end

  always_ff @(posedge bclk or negedge brst) begin
    if (!brst) begin
      state <= ST_IDLE;
      back  <= 1'b0;
      bload <= 1'b0;
    end else begin
      bload <= 1'b0;
      case (state)
        ST_IDLE: begin
          back <= 1'b0;
          // full buffer stalls here without acking
          if (req_s && (count < CW'(DEPTH))) begin
            state <= ST_CAPTURE;
            bload <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state <= ST_ACK;
          back  <= 1'b1;
        end
        ST_ACK: begin
          if (!req_s) begin
            state <= ST_IDLE;
            back  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          back  <= 1'b0;
        end
      endcase
    end
  end

endmodule
